scr1_pipe_dbga_mh: RTL

Multi-hart, parametrised debug agent: the run/halt controller between the debug controller (DBGC) and HARTS execution pipelines. It gives each hart its own run-control FSM, timeout counter and halt-cause record. It adds a counted single-step command and an optional halt group. It sits in the pipeline top, with one channel per EXU, and accepts one DBGC command at a time over a shared req/ack/nack handshake.

---
 rtl/scr1_pipe_dbga_mh_if.sv | 17 +
 rtl/scr1_pipe_dbga_mh.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/scr1_pipe_dbga_mh_if.sv
// scr1_pipe_dbga_mh_if: DBGC command handshake between debug controller and debug agent
// master: drives cmd_req, cmd_hart, cmd, cmd_steps; receives cmd_ack, cmd_nack
// slave : the debug agent side of the same signals
interface scr1_pipe_dbga_mh_if #(
   parameter int HARTS  = 2,
   parameter int STEP_W = 4
);
   localparam int HW = HARTS > 1 ? $clog2(HARTS) : 1;
   logic              cmd_req;
   logic [HW-1:0]     cmd_hart;
   logic [1:0]        cmd;
   logic [STEP_W-1:0] cmd_steps;
   logic              cmd_ack;
   logic              cmd_nack;
   modport master (output cmd_req, cmd_hart, cmd, cmd_steps, input cmd_ack, cmd_nack);
   modport slave  (input cmd_req, cmd_hart, cmd, cmd_steps, output cmd_ack, cmd_nack);
endinterface

// File: rtl/scr1_pipe_dbga_mh.sv
// scr1_pipe_dbga_mh: multi-hart run/halt debug agent with per-hart FSM, halt timeout and cause record
// clk, rst_n      : clock, asynchronous active-low reset
// dbgc            : shared DBGC command channel (req/hart/cmd/steps, ack/nack)
// rst_brk_en      : halt on reset-vector fetch enable
// brkpt_en        : halt on breakpoint enable
// exu_*, instret  : per-hart EXU status inputs
// halted ... timeout : per-hart run-control status outputs
// SCR1_DBGA_HALT_GROUP_EN: when defined, any hart halting pulls every other running/stepping hart into HALT_WAIT
module scr1_pipe_dbga_mh #(
   parameter int HARTS   = 2,
   parameter int TIMEOUT = 64,
   parameter int STEP_W  = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   scr1_pipe_dbga_mh_if.slave dbgc,
   input  logic               rst_brk_en,
   input  logic               brkpt_en,
   input  logic [HARTS-1:0]   exu_busy,
   input  logic [HARTS-1:0]   instret,
   input  logic [HARTS-1:0]   brkpt,
   input  logic [HARTS-1:0]   exu_init_pc,
   output logic [HARTS-1:0]   halted,
   output logic [HARTS-1:0]   run2halt,
   output logic [HARTS-1:0]   halt2run,
   output logic [HARTS-1:0]   run_start,
   output logic [HARTS-1:0]   sstep_en,
   output logic [HARTS-1:0]   no_commit,
   output logic [5*HARTS-1:0] cause,
   output logic [HARTS-1:0]   timeout
);
   localparam int CW = $clog2(TIMEOUT);
   localparam int HW = HARTS > 1 ? $clog2(HARTS) : 1;
   typedef enum logic [1:0] {RUN, HALT_WAIT, HALTED, STEP} state_t;
   logic [HARTS-1:0] hit, ack, nack;
   assign dbgc.cmd_ack  = |ack;
   assign dbgc.cmd_nack = |nack | (dbgc.cmd_req & ~|hit);
   for (genvar h = 0; h < HARTS; h++) begin : g_hart
      state_t            st, st_nxt;
      logic [CW-1:0]     cnt, cnt_nxt;
      logic [STEP_W-1:0] scnt, scnt_nxt;
      logic              pend, pend_nxt, gflag, gflag_nxt;
      logic              sel, hlt, go, stp, bp, rb, grp;
      logic              r2h, h2r, to, ack_l, refuse, to_r, rs;
      logic [4:0]        cz, cz_r;
      assign hit[h] = dbgc.cmd_hart == HW'(h);
      assign sel    = dbgc.cmd_req & hit[h];
      assign hlt    = sel & (dbgc.cmd == 2'b00);
      assign go     = sel & (dbgc.cmd == 2'b01);
      assign stp    = sel & (dbgc.cmd == 2'b10);
      assign bp     = brkpt_en & brkpt[h] & ~exu_busy[h];
      assign rb     = rst_brk_en & exu_init_pc[h] & ~exu_busy[h];
`ifdef SCR1_DBGA_HALT_GROUP_EN
      assign grp = |(run2halt & ~(HARTS'(1) << h));
`else
      assign grp = 1'b0;
`endif
      // the pending halt command is held on the bus while its hart waits; it must not be refused again
      assign refuse = sel & ~(st == HALT_WAIT & pend) &
                      ((dbgc.cmd == 2'b11) | (dbgc.cmd == 2'b00 & st != RUN) | ((dbgc.cmd[0] ^ dbgc.cmd[1]) & st != HALTED));
      always_comb begin
         r2h   = 1'b0;
         h2r   = 1'b0;
         to    = 1'b0;
         ack_l = 1'b0;
         cz    = 5'b0;
         case (st)
            RUN: begin
               r2h   = (hlt & ~exu_busy[h]) | bp | rb;
               ack_l = hlt & ~exu_busy[h];
               cz    = {1'b0, bp, 1'b0, rb, hlt};
            end
            HALT_WAIT: begin
               r2h   = ~exu_busy[h] | (cnt == '0);
               to    = exu_busy[h] & (cnt == '0);
               ack_l = pend & ~exu_busy[h];
               cz    = {gflag, 3'b0, pend};
            end
            HALTED: begin
               h2r   = go | stp;
               ack_l = go | stp;
            end
            STEP: begin
               r2h = bp | (instret[h] & scnt == STEP_W'(1));
               cz  = {1'b0, bp, instret[h] & scnt == STEP_W'(1), 2'b0};
            end
         endcase
      end
      always_comb begin
         st_nxt    = st;
         cnt_nxt   = cnt;
         pend_nxt  = pend;
         gflag_nxt = gflag;
         scnt_nxt  = (st == STEP & instret[h]) ? scnt - 1'b1 : scnt;
         if (r2h) begin
            st_nxt    = HALTED;
            cnt_nxt   = CW'(TIMEOUT - 1);
            pend_nxt  = 1'b0;
            gflag_nxt = 1'b0;
         end else if (h2r) begin
            st_nxt   = stp ? STEP : RUN;
            scnt_nxt = stp ? (dbgc.cmd_steps == '0 ? STEP_W'(1) : dbgc.cmd_steps) : scnt;
         end else if (st == RUN & hlt) begin
            // the entry cycle already counts toward the timeout
            st_nxt   = HALT_WAIT;
            cnt_nxt  = CW'(TIMEOUT - 2);
            pend_nxt = 1'b1;
         end else if ((st == RUN | st == STEP) & grp) begin
            st_nxt    = HALT_WAIT;
            cnt_nxt   = CW'(TIMEOUT - 2);
            gflag_nxt = 1'b1;
         end else if (st == HALT_WAIT) begin
            cnt_nxt = cnt - 1'b1;
         end
      end
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            st    <= RUN;
            cnt   <= CW'(TIMEOUT - 1);
            scnt  <= '0;
            pend  <= 1'b0;
            gflag <= 1'b0;
            cz_r  <= 5'b0;
            to_r  <= 1'b0;
            rs    <= 1'b0;
         end else begin
            st    <= st_nxt;
            cnt   <= cnt_nxt;
            scnt  <= scnt_nxt;
            pend  <= pend_nxt;
            gflag <= gflag_nxt;
            rs    <= h2r;
            if (r2h) begin
               cz_r <= cz;
               to_r <= to;
            end else if (h2r) begin
               to_r <= 1'b0;
            end
         end
      end
      assign ack[h]         = ack_l;
      assign nack[h]        = refuse | (pend & to);
      assign halted[h]      = st == HALTED;
      assign sstep_en[h]    = st == STEP;
      assign run2halt[h]    = r2h;
      assign halt2run[h]    = h2r;
      assign run_start[h]   = rs;
      assign no_commit[h]   = bp & (st == RUN | st == STEP);
      assign cause[5*h +: 5] = cz_r;
      assign timeout[h]     = to_r;
   end
endmodule
